// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Asynchronous serial receiver. Pairs with the UartTx transmitter: given the
// same divider, parity and stop-bit settings, a TX -> RX loop reproduces the
// transmitted bytes. Each completed frame is reported by a one-clock valid_o
// pulse. The received byte and its parity/framing status are held until the
// next frame completes.
//
// Ports
//   clock_i          system clock
//   reset_n_i        asynchronous, active-low reset
//   serial_i         asynchronous serial line, idle high
//   clock_divider_i  bit period in clocks minus one (valid range 1..65535)
//   parity_bit_i     1 = a parity bit follows the data bits
//   parity_even_i    1 = even parity, 0 = odd parity
//   two_stop_bits_i  1 = two stop bits are expected
//   data_o           last received data word, LSB first on the line
//   valid_o          one-clock pulse when a frame completes
//   parity_error_o   parity status of the frame flagged by valid_o
//   framing_error_o  stop-bit status of the frame flagged by valid_o
//   busy_o           high from start-bit detection until the frame ends
//
// Timing: a falling edge of the synchronised line loads the bit counter with
// half a bit period, so every following sample falls near the middle of its
// bit. The configuration inputs are captured when the start bit is detected
// and stay fixed for the rest of that frame.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 serial_i,
  input  logic [15:0]          clock_divider_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_even_i,
  input  logic                 two_stop_bits_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_error_o,
  output logic                 framing_error_o,
  output logic                 busy_o
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // The stages reset to 1, so the chain holds no real line samples until it
  // has been refilled. sync_vld_q follows the samples through the chain, so a
  // line held low out of reset is not taken for a falling edge.
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   s_d_q, s_d_vld_q;
  logic                   s;
  logic                   fall;

  assign s          = sync_q[SYNC_STAGES-1];
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], serial_i};
  assign sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
  assign fall       = s_d_vld_q && s_d_q && !s;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q     <= '1;
      sync_vld_q <= '0;
      s_d_q      <= 1'b1;
      s_d_vld_q  <= 1'b0;
    end else begin
      // NOTE: every clocked assignment is non-blocking, so each stage takes
      // its neighbour's value from before the edge and the chain shifts by
      // exactly one position per clock.
      sync_q     <= sync_d;
      sync_vld_q <= sync_vld_d;
      s_d_q      <= s;
      s_d_vld_q  <= sync_vld_q[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [16:0]            cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   ferr_acc_q, ferr_acc_d;

  // Configuration captured at start detection
  logic [15:0]            div_q, div_d;
  logic                   par_en_q, par_en_d;
  logic                   par_even_q, par_even_d;
  logic                   two_stop_q, two_stop_d;

  // Registered outputs
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  logic [16:0]            period;
  logic [16:0]            half_in;
  logic                   expiry;
  logic                   start_go;
  logic                   frame_done;
  logic                   ferr_fin;
  logic                   par_xor;

  // The period of a frame in progress comes from the captured divider; the
  // half period used at detection comes straight from the input, because the
  // configuration is captured on that same clock.
  assign period  = {1'b0, div_q} + 17'd1;
  assign half_in = ({1'b0, clock_divider_i} + 17'd1) >> 1;
  // A counter value of 1 marks the sample clock. "<= 1" also covers a value
  // of 0, so an unsupported divider of 0 cannot wrap the counter.
  assign expiry  = (cnt_q <= 17'd1);
  // Parity is checked over the data word and the received parity bit together.
  assign par_xor = (^shift_q) ^ s;

  always_comb begin
    // NOTE: every signal written below gets a default first. A path that
    // left one unassigned would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    two_stop_d = two_stop_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    busy_d     = busy_q;
    start_go   = 1'b0;
    frame_done = 1'b0;
    ferr_fin   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_go = fall;
      end

      ST_START: begin
        if (expiry) begin
          if (s) begin
            // The line went high again before mid-bit: a glitch, not a start
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d     = period;
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end

      ST_DATA: begin
        if (expiry) begin
          // The line sends LSB first. Each new bit enters at the MSB, so the
          // first bit received ends up at bit 0.
          shift_d   = {s, shift_q[DATA_BITS-1:1]};
          cnt_d     = period;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end

      ST_PARITY: begin
        if (expiry) begin
          perr_acc_d = par_even_q ? par_xor : !par_xor;
          cnt_d      = period;
          state_d    = ST_STOP1;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end

      ST_STOP1: begin
        if (expiry) begin
          if (two_stop_q) begin
            ferr_acc_d = !s;
            cnt_d      = period;
            state_d    = ST_STOP2;
          end else begin
            frame_done = 1'b1;
            ferr_fin   = !s;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end

      ST_STOP2: begin
        if (expiry) begin
          frame_done = 1'b1;
          ferr_fin   = ferr_acc_q | !s;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        // A start bit that follows a single stop bit directly can fall on
        // this cycle. Accept it here so that back-to-back frames are not lost.
        start_go = fall;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (frame_done) begin
      state_d = ST_DONE;
      data_d  = shift_q;
      perr_d  = perr_acc_q;
      ferr_d  = ferr_fin;
      valid_d = 1'b1;
      busy_d  = 1'b0;
    end

    if (start_go) begin
      state_d    = ST_START;
      cnt_d      = half_in;
      bit_cnt_d  = '0;
      perr_acc_d = 1'b0;
      ferr_acc_d = 1'b0;
      busy_d     = 1'b1;
      div_d      = clock_divider_i;
      par_en_d   = parity_bit_i;
      par_even_d = parity_even_i;
      two_stop_d = two_stop_bits_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      two_stop_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      two_stop_q <= two_stop_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign parity_error_o  = perr_q;
  assign framing_error_o = ferr_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed and randomised frames drive uart_rx from a serial-line model. A
// negedge monitor records every valid_o pulse. Each recorded frame is compared
// with the result that a frame-level reference model predicts from the data,
// the parity bit and the stop bits that were driven.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } rx_t;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        serial_i = 1'b0;
  logic [15:0] clock_divider_i = 16'd9;
  logic        parity_bit_i = 1'b0;
  logic        parity_even_i = 1'b1;
  logic        two_stop_bits_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        parity_error_o;
  logic        framing_error_o;
  logic        busy_o;

  int   checks = 0;
  int   errors = 0;
  rx_t  rx_q[$];
  int   valid_cnt = 0;
  bit   multi_valid = 1'b0;
  bit   busy_seen = 1'b0;
  logic valid_prev = 1'b0;
  logic [7:0] last_data = 8'h00;

  uart_rx #(.SYNC_STAGES(2), .DATA_BITS(8)) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .serial_i        (serial_i),
    .clock_divider_i (clock_divider_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .two_stop_bits_i (two_stop_bits_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .parity_error_o  (parity_error_o),
    .framing_error_o (framing_error_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Monitor: runs on the falling edge, between the DUT's active edges
  always @(negedge clock_i) begin : monitor
    rx_t r;
    if (valid_o) begin
      r.data = data_o;
      r.perr = parity_error_o;
      r.ferr = framing_error_o;
      r.busy = busy_o;
      rx_q.push_back(r);
      valid_cnt++;
    end
    if (valid_o && valid_prev) multi_valid = 1'b1;
    valid_prev = valid_o;
    if (busy_o) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the report a correct receiver gives for a frame with
  // these line contents.
  function automatic rx_t model(input logic [7:0] d, input bit par_en, input bit par_even,
                                input bit pbit, input bit two_stop, input bit s1, input bit s2);
    rx_t r;
    int  ones;
    ones   = $countones(d) + int'(pbit);
    r.data = d;
    r.perr = par_en && (par_even ? (ones % 2 != 0) : (ones % 2 != 1));
    r.ferr = !s1 || (two_stop && !s2);
    r.busy = 1'b0;
    return r;
  endfunction

  task automatic set_cfg(input int div, input bit par_en, input bit par_even, input bit two_stop);
    clock_divider_i = 16'(div);
    parity_bit_i    = par_en;
    parity_even_i   = par_even;
    two_stop_bits_i = two_stop;
  endtask

  task automatic drive_bit(input bit b, input int p);
    serial_i = b;
    repeat (p) @(negedge clock_i);
  endtask

  task automatic idle(input int bits, input int p);
    drive_bit(1'b1, bits * p);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit par_en, input bit pbit,
                            input bit two_stop, input bit s1, input bit s2);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (par_en) drive_bit(pbit, p);
    drive_bit(s1, p);
    if (two_stop) drive_bit(s2, p);
  endtask

  task automatic expect_frame(input string tag, input rx_t exp);
    rx_t got;
    for (int i = 0; i < 4000 && rx_q.size() == 0; i++) @(negedge clock_i);
    check({tag, "_arrive"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) begin
      got = rx_q.pop_front();
      check(tag, 32'(got), 32'(exp));
      last_data = exp.data;
    end
  endtask

  initial begin
    int vc;

    // Reset with the line held low: outputs at reset values, and the low
    // line is not taken as a start after release.
    set_cfg(9, 0, 1, 0);
    serial_i  = 1'b0;
    reset_n_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("rst_data",  32'(data_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_perr",  32'(parity_error_o), 32'h0);
    check("rst_ferr",  32'(framing_error_o), 32'h0);
    check("rst_busy",  32'(busy_o), 32'h0);
    reset_n_i = 1'b1;
    repeat (60) @(negedge clock_i);
    check("held_low_no_busy",  32'(busy_seen), 32'h0);
    check("held_low_no_frame", 32'(valid_cnt), 32'h0);
    idle(3, 10);

    // Loopback at divider 1, back-to-back frames with a single stop bit
    set_cfg(1, 0, 1, 0);
    send_frame(8'h55, 2, 0, 0, 0, 1, 1);
    send_frame(8'hAA, 2, 0, 0, 0, 1, 1);
    idle(4, 2);
    expect_frame("loop_55", model(8'h55, 0, 1, 0, 0, 1, 1));
    expect_frame("loop_AA", model(8'hAA, 0, 1, 0, 0, 1, 1));

    // Reset in the middle of the 4th data bit, then a clean frame
    set_cfg(9, 0, 1, 0);
    drive_bit(1'b0, 10);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h3C >> i), 10);
    serial_i = 1'b1;
    repeat (5) @(negedge clock_i);
    reset_n_i = 1'b0;
    #1;
    check("midrst_data",  32'(data_o), 32'h0);
    check("midrst_busy",  32'(busy_o), 32'h0);
    check("midrst_flags", 32'({valid_o, parity_error_o, framing_error_o}), 32'h0);
    repeat (5) @(negedge clock_i);
    reset_n_i = 1'b1;
    idle(3, 10);
    check("midrst_no_partial", 32'(rx_q.size()), 32'd0);
    vc = valid_cnt;
    send_frame(8'h3C, 10, 0, 0, 0, 1, 1);
    idle(2, 10);
    expect_frame("midrst_3C", model(8'h3C, 0, 1, 0, 0, 1, 1));
    check("midrst_one_pulse", 32'(valid_cnt), 32'(vc + 1));

    // Parity, divider 4
    set_cfg(4, 1, 1, 0);
    send_frame(8'h07, 5, 1, 1, 0, 1, 1); idle(2, 5);
    expect_frame("par_even_ok", model(8'h07, 1, 1, 1, 0, 1, 1));
    send_frame(8'h07, 5, 1, 0, 0, 1, 1); idle(2, 5);
    expect_frame("par_even_bad", model(8'h07, 1, 1, 0, 0, 1, 1));
    set_cfg(4, 1, 0, 0);
    send_frame(8'h07, 5, 1, 0, 0, 1, 1); idle(2, 5);
    expect_frame("par_odd_ok", model(8'h07, 1, 0, 0, 0, 1, 1));
    send_frame(8'h07, 5, 1, 1, 0, 1, 1); idle(2, 5);
    expect_frame("par_odd_bad", model(8'h07, 1, 0, 1, 0, 1, 1));

    // Glitch: 3-clock low pulse at divider 9
    set_cfg(9, 0, 1, 0);
    idle(2, 10);
    vc = valid_cnt;
    busy_seen = 1'b0;
    drive_bit(1'b0, 3);
    idle(4, 10);
    check("glitch_busy_pulse", 32'(busy_seen), 32'd1);
    check("glitch_busy_low",   32'(busy_o), 32'd0);
    check("glitch_no_valid",   32'(valid_cnt), 32'(vc));
    check("glitch_data_held",  32'(data_o), 32'(last_data));

    // Framing: second stop bit low, then a break of 40 bit times
    set_cfg(9, 0, 1, 1);
    send_frame(8'hA5, 10, 0, 0, 1, 1, 0); idle(2, 10);
    expect_frame("frame_stop2", model(8'hA5, 0, 1, 0, 1, 1, 0));
    vc = valid_cnt;
    drive_bit(1'b0, 40 * 10);
    idle(4, 10);
    expect_frame("break", model(8'h00, 0, 1, 0, 1, 0, 0));
    check("break_one_frame", 32'(valid_cnt), 32'(vc + 1));

    // The divider changes during DATA; the frame in flight keeps its period
    set_cfg(9, 0, 1, 0);
    fork
      send_frame(8'hC3, 10, 0, 0, 0, 1, 1);
      begin
        repeat (30) @(negedge clock_i);
        clock_divider_i = 16'd1;
      end
    join
    idle(3, 10);
    expect_frame("cfg_latch_C3", model(8'hC3, 0, 1, 0, 0, 1, 1));
    send_frame(8'h3E, 2, 0, 0, 0, 1, 1); idle(4, 2);
    expect_frame("cfg_next_div1", model(8'h3E, 0, 1, 0, 0, 1, 1));

    // Randomised frames
    for (int n = 0; n < 16; n++) begin
      int         div;
      bit         pe, pv, pb, ts, s1, s2;
      logic [7:0] d;
      div = $urandom_range(1, 6);
      pe  = 1'($urandom_range(0, 1));
      pv  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      ts  = 1'($urandom_range(0, 1));
      s1  = ($urandom_range(0, 3) != 0);
      s2  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      set_cfg(div, pe, pv, ts);
      send_frame(d, div + 1, pe, pb, ts, s1, s2);
      idle(2, div + 1);
      expect_frame("rand", model(d, pe, pv, pb, ts, s1, s2));
    end

    idle(4, 10);
    check("valid_single_cycle", 32'(multi_valid), 32'd0);
    check("no_spurious_frames", 32'(rx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
